// File: rtl/poly_pkg.sv
// Shared types and constants for the polynomial evaluator front-end.
// Holds the feeder FSM encoding and the operand beat indices.
package poly_pkg;

  localparam int DATA_W = 8;

  localparam logic [1:0] OP_A = 2'd0;
  localparam logic [1:0] OP_B = 2'd1;
  localparam logic [1:0] OP_C = 2'd2;
  localparam logic [1:0] OP_X = 2'd3;

  typedef enum logic [1:0] {
    S_ACCEPT,
    S_GO,
    S_GAP,
    S_WAIT_RES
  } feeder_state_t;

endpackage

// File: rtl/result_slot.sv
// One-entry valid/ready holding register for evaluator results.
// A load is only issued while the slot is empty.
module result_slot
  import poly_pkg::*;
(
  input  logic              Clock,
  input  logic              Reset,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              full
);

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= load_data;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign full = out_valid;

endmodule

// File: rtl/poly_operand_feeder.sv
// Replays A,B,C,X beats onto the evaluator Go/DataIn handshake
// and buffers the evaluator result on a valid/ready stream.
module poly_operand_feeder
  import poly_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              Go,
  output logic [DATA_W-1:0] DataIn,
  input  logic [DATA_W-1:0] DataResult,
  input  logic              ResultValid,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              err
);

  localparam int CW = $clog2(TIMEOUT + 1);

  feeder_state_t     state, state_d;
  logic [1:0]        k, k_d;
  logic [DATA_W-1:0] opnd, opnd_d;
  logic [CW-1:0]     cnt, cnt_d;
  logic              load;
  logic              full;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state <= S_ACCEPT;
      k     <= OP_A;
      opnd  <= '0;
      cnt   <= '0;
    end else begin
      state <= state_d;
      k     <= k_d;
      opnd  <= opnd_d;
      cnt   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state;
    k_d      = k;
    opnd_d   = opnd;
    cnt_d    = cnt;
    load     = 1'b0;
    err      = 1'b0;
    in_ready = 1'b0;
    Go       = 1'b0;
    DataIn   = '0;
    unique case (state)
      S_ACCEPT: begin
        in_ready = !Reset;
        if (in_valid) begin
          opnd_d  = in_data;
          state_d = S_GO;
        end
      end
      S_GO: begin
        Go      = 1'b1;
        DataIn  = opnd;
        state_d = S_GAP;
      end
      S_GAP: begin
        DataIn = opnd;
        if (k == OP_X) begin
          k_d     = OP_A;
          cnt_d   = '0;
          state_d = S_WAIT_RES;
        end else begin
          k_d     = k + 2'd1;
          state_d = S_ACCEPT;
        end
      end
      S_WAIT_RES: begin
        // evaluator holds its result until next Go, so a full slot just stalls
        if (ResultValid) begin
          if (!full) begin
            load    = 1'b1;
            state_d = S_ACCEPT;
          end
        end else if (cnt == CW'(TIMEOUT)) begin
          err     = 1'b1;
          k_d     = OP_A;
          state_d = S_ACCEPT;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      default: state_d = S_ACCEPT;
    endcase
  end

  result_slot u_slot (
    .Clock     (Clock),
    .Reset     (Reset),
    .load      (load),
    .load_data (DataResult),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .full      (full)
  );

endmodule

// File: tb/tb_poly_operand_feeder.sv
// Scoreboard bench for poly_operand_feeder with a behavioural evaluator.
// Expected results are computed from A*X^2+B*X+C mod 256 at issue time.
module tb_poly_operand_feeder;

  logic       Clock;
  logic       Reset;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       Go;
  logic [7:0] DataIn;
  logic [7:0] DataResult;
  logic       ResultValid;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       err;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int err_cnt = 0;
  int res_q[$];
  int go_q[$];
  logic eval_dead = 1'b0;
  logic rnd_done;

  poly_operand_feeder #(.TIMEOUT(16)) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .Go          (Go),
    .DataIn      (DataIn),
    .DataResult  (DataResult),
    .ResultValid (ResultValid),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .err         (err)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;
  always @(posedge Clock) cyc <= cyc + 1;

  task automatic check(input string nm, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, got, exp, cyc);
  endtask

  task automatic fail(input string nm);
    n_chk++;
    $display("FAIL %s: event missing or unexpected (cycle %0d)", nm, cyc);
  endtask

  // Behavioural evaluator: result ready 7 cycles after the X Go cycle.
  logic [7:0] ev_op[4];
  int ev_idx;
  int ev_cnt;
  always @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      ev_idx <= 0;
      ev_cnt <= 0;
      ResultValid <= 1'b0;
      DataResult <= 8'd0;
    end else if (Go) begin
      ev_op[ev_idx] <= DataIn;
      ResultValid <= 1'b0;
      if (ev_idx == 3) begin
        ev_idx <= 0;
        ev_cnt <= 6;
      end else begin
        ev_idx <= ev_idx + 1;
      end
    end else if (ev_cnt > 0) begin
      ev_cnt <= ev_cnt - 1;
      if (ev_cnt == 1 && !eval_dead) begin
        ResultValid <= 1'b1;
        DataResult <= 8'(ev_op[0] * ev_op[3] * ev_op[3]
                         + ev_op[1] * ev_op[3] + ev_op[2]);
      end
    end
  end

  // Output monitor
  always @(negedge Clock) begin
    if (!Reset && out_valid && out_ready) begin
      if (res_q.size() == 0) fail("out_extra");
      else check("out_data", out_data, res_q.pop_front());
    end
    if (err) err_cnt++;
  end

  // Go/DataIn monitor
  logic       prev_go = 1'b0;
  logic [7:0] prev_din = 8'd0;
  always @(negedge Clock) begin
    if (Reset) begin
      prev_go = 1'b0;
    end else begin
      if (prev_go) begin
        check("go_width", Go, 0);
        check("din_gap", DataIn, prev_din);
      end else if (Go) begin
        if (go_q.size() == 0) fail("go_extra");
        else check("go_din", DataIn, go_q.pop_front());
      end
      prev_go = Go;
      prev_din = DataIn;
    end
  end

  task automatic set_or(input logic v);
    @(posedge Clock);
    #1 out_ready = v;
  endtask

  task automatic send_beat(input int v, input int gap);
    bit ok = 0;
    repeat (gap) @(negedge Clock);
    @(negedge Clock);
    in_valid = 1'b1;
    in_data = 8'(v);
    go_q.push_back(v);
    for (int i = 0; i < 200; i++) begin
      if (in_ready) begin
        ok = 1;
        break;
      end
      @(negedge Clock);
    end
    if (!ok) fail("accept_timeout");
    @(posedge Clock);
    #1 in_valid = 1'b0;
  endtask

  task automatic send_packet(input int a, input int b, input int c,
                             input int x, input int gap, input bit exp);
    if (exp) res_q.push_back((a * x * x + b * x + c) % 256);
    send_beat(a, gap);
    send_beat(b, gap);
    send_beat(c, gap);
    send_beat(x, gap);
  endtask

  task automatic drain();
    for (int i = 0; i < 300; i++) begin
      if (res_q.size() == 0 && !out_valid) break;
      @(negedge Clock);
    end
    check("drain_left", res_q.size(), 0);
  endtask

  task automatic wait_ov();
    bit ok = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge Clock);
      if (out_valid) begin
        ok = 1;
        break;
      end
    end
    if (!ok) fail("out_valid_timeout");
  endtask

  initial begin
    int c0;
    int hit;
    Reset = 1'b1;
    in_valid = 1'b0;
    in_data = 8'd0;
    out_ready = 1'b1;
    repeat (3) @(negedge Clock);
    check("rst_in_ready", in_ready, 0);
    check("rst_go", Go, 0);
    check("rst_datain", DataIn, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_err", err, 0);
    Reset = 1'b0;
    @(negedge Clock);
    check("rel_in_ready", in_ready, 1);

    // Basic packet with latency check
    send_packet(2, 3, 4, 5, 0, 1);
    c0 = cyc;
    hit = -1;
    for (int i = 0; i < 30; i++) begin
      @(negedge Clock);
      if (cyc == c0 + 7) check("busy_in_ready", in_ready, 0);
      if (out_valid) begin
        hit = cyc;
        check("res_in_ready", in_ready, 1);
        break;
      end
    end
    check("latency", hit - c0, 8);
    drain();

    // Wrap-around
    send_packet(10, 0, 0, 10, 0, 1);
    drain();

    // Back-pressure
    set_or(0);
    send_packet(2, 3, 4, 5, 0, 1);
    wait_ov();
    send_packet(1, 1, 1, 1, 0, 1);
    repeat (20) @(negedge Clock);
    check("bp_in_ready", in_ready, 0);
    check("bp_out_valid", out_valid, 1);
    check("bp_out_data", out_data, 69);
    set_or(1);
    drain();

    // Slow producer
    send_packet(2, 3, 4, 5, 5, 1);
    drain();

    // Timeout
    eval_dead = 1'b1;
    hit = err_cnt;
    send_packet(1, 2, 3, 4, 0, 0);
    c0 = cyc;
    for (int i = 0; i < 40; i++) begin
      @(negedge Clock);
      if (err) break;
    end
    check("err_cycle", cyc - c0, 18);
    @(negedge Clock);
    check("err_count", err_cnt - hit, 1);
    check("to_in_ready", in_ready, 1);
    check("to_out_valid", out_valid, 0);
    eval_dead = 1'b0;

    // Reset mid-packet with a pending result
    set_or(0);
    send_packet(2, 3, 4, 5, 0, 1);
    wait_ov();
    send_beat(7, 0);
    send_beat(8, 0);
    repeat (4) @(negedge Clock);
    #2 Reset = 1'b1;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_in_ready", in_ready, 0);
    check("mid_rst_datain", DataIn, 0);
    check("mid_rst_out_data", out_data, 0);
    res_q.delete();
    go_q.delete();
    repeat (2) @(negedge Clock);
    Reset = 1'b0;
    set_or(1);
    @(negedge Clock);
    check("post_rst_in_ready", in_ready, 1);
    send_packet(2, 3, 4, 5, 0, 1);
    drain();

    // Randomized packets with random back-pressure
    hit = err_cnt;
    rnd_done = 1'b0;
    fork
      begin
        for (int p = 0; p < 20; p++) begin
          send_packet($urandom_range(0, 255), $urandom_range(0, 255),
                      $urandom_range(0, 255), $urandom_range(0, 255),
                      $urandom_range(0, 3), 1);
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge Clock);
          #1 out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    set_or(1);
    drain();
    check("no_spurious_err", err_cnt - hit, 0);
    check("go_q_empty", go_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
